// File: rtl/draw_scheduler_pkg.sv
// Shared definitions for the per-frame draw sequencer and its helpers.
package draw_scheduler_pkg;

   localparam int unsigned NUM_TASKS = 6;

   localparam int unsigned TASK_SCREEN = 0;
   localparam int unsigned TASK_LEVEL  = 1;
   localparam int unsigned TASK_PADDLE = 2;
   localparam int unsigned TASK_BALL   = 3;
   localparam int unsigned TASK_SCORE  = 4;
   localparam int unsigned TASK_LIFE   = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_RST,
      ST_RUN,
      ST_DONE
   } state_t;

endpackage

// File: rtl/draw_scheduler_prio_encoder.sv
// Lowest-set-bit finder: valid flag plus index of the first requesting bit.
module prio_encoder #(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned IDX_W = 3
) (
   input  logic [WIDTH-1:0] req,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (req[i] && !valid) begin
            valid = 1'b1;
            idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/draw_scheduler.sv
// Per-frame draw sequencer: walks pending draw tasks in priority order,
// pulsing each task's reset then holding its enable until end or timeout.
module draw_scheduler #(
   parameter int unsigned NUM_TASKS      = draw_scheduler_pkg::NUM_TASKS,
   parameter int unsigned TIMEOUT_CYCLES = 20000,
   parameter int unsigned TIMEOUT_W      = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 frameTick,
   input  logic                 gameRun,
   input  logic                 forceAll,
   input  logic [NUM_TASKS-1:0] drawReq,
   input  logic [NUM_TASKS-1:0] taskEnd,
   input  logic                 clearErr,
   output logic [NUM_TASKS-1:0] taskEnable,
   output logic [NUM_TASKS-1:0] taskReset,
   output logic                 busy,
   output logic                 frameDone,
   output logic                 overrun,
   output logic                 timeoutErr,
   output logic [2:0]           timeoutIdx
);
   import draw_scheduler_pkg::*;

   localparam int unsigned IDX_W = 3;

   state_t               state;
   state_t               state_next;
   logic [NUM_TASKS-1:0] pending;
   logic [NUM_TASKS-1:0] cur_onehot;
   logic                 first_frame;
   logic [IDX_W-1:0]     cur;
   logic [TIMEOUT_W-1:0] tcnt;
   logic                 sel_valid;
   logic [IDX_W-1:0]     sel_idx;
   logic                 accept;
   logic                 task_done;
   logic                 timeout_hit;
   logic                 tick_overrun;

   prio_encoder #(
      .WIDTH (NUM_TASKS),
      .IDX_W (IDX_W)
   ) u_prio (
      .req   (pending),
      .valid (sel_valid),
      .idx   (sel_idx)
   );

   assign cur_onehot   = NUM_TASKS'(1) << cur;
   assign tick_overrun = frameTick && (state != ST_IDLE);

   always_comb begin
      state_next  = state;
      accept      = 1'b0;
      task_done   = 1'b0;
      timeout_hit = 1'b0;
      taskEnable  = '0;
      taskReset   = '0;
      busy        = 1'b0;
      frameDone   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (frameTick && gameRun) begin
               accept     = 1'b1;
               state_next = ST_SELECT;
            end
         end
         ST_SELECT: begin
            busy       = 1'b1;
            state_next = sel_valid ? ST_RST : ST_DONE;
         end
         ST_RST: begin
            busy       = 1'b1;
            taskReset  = cur_onehot;
            state_next = ST_RUN;
         end
         ST_RUN: begin
            busy       = 1'b1;
            taskEnable = cur_onehot;
            // A real end on the final allowed cycle takes precedence over timeout.
            if (|(taskEnd & cur_onehot)) begin
               task_done  = 1'b1;
               state_next = ST_SELECT;
            end else if (tcnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
               timeout_hit = 1'b1;
               state_next  = ST_SELECT;
            end
         end
         ST_DONE: begin
            frameDone  = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         pending     <= '0;
         first_frame <= 1'b1;
         cur         <= '0;
         tcnt        <= '0;
         overrun     <= 1'b0;
         timeoutErr  <= 1'b0;
         timeoutIdx  <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            pending     <= drawReq | {NUM_TASKS{forceAll | first_frame}};
            first_frame <= 1'b0;
         end else if (task_done || timeout_hit) begin
            pending <= pending & ~cur_onehot;
         end
         if (state == ST_SELECT && sel_valid) cur <= sel_idx;
         if (state == ST_RST)      tcnt <= '0;
         else if (state == ST_RUN) tcnt <= tcnt + 1'b1;
         // Sticky flags: a new error in the clearing cycle keeps the flag set.
         overrun    <= (overrun & ~clearErr) | tick_overrun;
         timeoutErr <= (timeoutErr & ~clearErr) | timeout_hit;
         if (timeout_hit) timeoutIdx <= cur;
      end
   end

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler: stimulus pushes expected reset/enable/done
// events; a negedge monitor pops and compares them as the DUT produces them.
module tb_draw_scheduler;

   localparam int KIND_RST  = 0;
   localparam int KIND_EN   = 1;
   localparam int KIND_DONE = 2;

   typedef struct {
      int kind;
      int idx;
      int len;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       frameTick;
   logic       gameRun;
   logic       forceAll;
   logic [5:0] drawReq;
   logic [5:0] taskEnd;
   logic       clearErr;
   logic [5:0] taskEnable;
   logic [5:0] taskReset;
   logic       busy;
   logic       frameDone;
   logic       overrun;
   logic       timeoutErr;
   logic [2:0] timeoutIdx;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   tick_cyc = 0;
   int   end_after[6];
   int   run_cnt[6];
   int   en_len = 0;
   int   en_idx = 0;

   draw_scheduler #(
      .NUM_TASKS      (6),
      .TIMEOUT_CYCLES (16),
      .TIMEOUT_W      (15)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .frameTick  (frameTick),
      .gameRun    (gameRun),
      .forceAll   (forceAll),
      .drawReq    (drawReq),
      .taskEnd    (taskEnd),
      .clearErr   (clearErr),
      .taskEnable (taskEnable),
      .taskReset  (taskReset),
      .busy       (busy),
      .frameDone  (frameDone),
      .overrun    (overrun),
      .timeoutErr (timeoutErr),
      .timeoutIdx (timeoutIdx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Datapath model: task i raises its end level on its end_after[i]-th enabled cycle.
   always begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) begin
         if (taskReset[i]) begin
            run_cnt[i] = 0;
            taskEnd[i] = 1'b0;
         end else if (taskEnable[i]) begin
            run_cnt[i]++;
            if (end_after[i] != 0 && run_cnt[i] >= end_after[i]) taskEnd[i] = 1'b1;
         end
      end
   end

   function automatic int ohidx(input logic [5:0] v);
      if ($countones(v) != 1) return 7;
      for (int i = 0; i < 6; i++) if (v[i]) return i;
      return 7;
   endfunction

   task automatic pop_check(input int kind, input int idx, input int len);
      exp_t e;
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $display("FAIL sb_unexpected: got kind=%0d idx=%0d len=%0d, required no event",
                  kind, idx, len);
      end else begin
         e = sb.pop_front();
         if (e.kind != kind || e.idx != idx || e.len != len) begin
            fails++;
            $display("FAIL sb_event: got kind=%0d idx=%0d len=%0d, required kind=%0d idx=%0d len=%0d",
                     kind, idx, len, e.kind, e.idx, e.len);
         end
      end
   endtask

   always @(negedge clk) begin
      if (taskReset != '0) pop_check(KIND_RST, ohidx(taskReset), 0);
      if (taskEnable != '0) begin
         if (en_len == 0) en_idx = ohidx(taskEnable);
         else if (ohidx(taskEnable) != en_idx) en_idx = 7;
         en_len++;
      end else if (en_len != 0) begin
         pop_check(KIND_EN, en_idx, en_len);
         en_len = 0;
      end
      if (frameDone) pop_check(KIND_DONE, 0, cyc - tick_cyc);
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic push_task(input int idx, input int len);
      sb.push_back('{KIND_RST, idx, 0});
      sb.push_back('{KIND_EN, idx, len});
   endtask

   task automatic push_done(input int lat);
      sb.push_back('{KIND_DONE, 0, lat});
   endtask

   task automatic set_ends(input int n);
      for (int i = 0; i < 6; i++) end_after[i] = n;
   endtask

   task automatic tick(input logic [5:0] req, input bit accepted);
      @(posedge clk);
      #1;
      drawReq   = req;
      frameTick = 1'b1;
      if (accepted) tick_cyc = cyc;
      @(posedge clk);
      #1;
      frameTick = 1'b0;
   endtask

   task automatic pulse_clear();
      @(posedge clk);
      #1 clearErr = 1'b1;
      @(posedge clk);
      #1 clearErr = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(posedge clk);
         #2;
         if (sb.size() == 0 && !busy && !frameDone) done = 1'b1;
      end
      chk(name, int'(done), 1);
   endtask

   initial begin
      reset = 1'b1; frameTick = 1'b0; gameRun = 1'b1; forceAll = 1'b0;
      drawReq = '0; clearErr = 1'b0; taskEnd = '0;
      set_ends(2);
      for (int i = 0; i < 6; i++) run_cnt[i] = 0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_enable", int'(taskEnable), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_flags", int'({overrun, timeoutErr, frameDone}), 0);
      #1 reset = 1'b0;

      // First frame after reset draws everything.
      for (int i = 0; i < 6; i++) push_task(i, 2);
      push_done(26);
      tick(6'b000000, 1'b1);
      wait_idle("f1_drain");
      chk("f1_overrun", int'(overrun), 0);

      // Only dirty tasks 2 and 3.
      set_ends(3);
      push_task(2, 3); push_task(3, 3); push_done(12);
      tick(6'b001100, 1'b1);
      wait_idle("f2_drain");

      // Paused tick is ignored.
      gameRun = 1'b0;
      tick(6'b111111, 1'b0);
      repeat (4) @(posedge clk);
      #2 chk("pause_busy", int'(busy), 0);
      gameRun = 1'b1;

      // Pause mid-frame does not abort.
      push_task(0, 3); push_done(7);
      tick(6'b000001, 1'b1);
      gameRun = 1'b0;
      wait_idle("f4_drain");
      gameRun = 1'b1;

      // Empty frame still completes two cycles after the tick.
      push_done(2);
      tick(6'b000000, 1'b1);
      wait_idle("f5_drain");

      // forceAll draws all tasks.
      set_ends(1);
      forceAll = 1'b1;
      for (int i = 0; i < 6; i++) push_task(i, 1);
      push_done(20);
      tick(6'b000000, 1'b1);
      forceAll = 1'b0;
      wait_idle("f6_drain");

      // Task 4 never ends: abandoned after 16 enable cycles, task 5 still runs.
      set_ends(2);
      end_after[4] = 0;
      push_task(4, 16); push_task(5, 2); push_done(24);
      tick(6'b110000, 1'b1);
      wait_idle("f7_drain");
      chk("to_err", int'(timeoutErr), 1);
      chk("to_idx", int'(timeoutIdx), 4);
      pulse_clear();
      #1 chk("to_cleared", int'(timeoutErr), 0);

      // Tick while busy: flagged, dropped.
      set_ends(3);
      push_task(2, 3); push_done(7);
      tick(6'b000100, 1'b1);
      tick(6'b111111, 1'b0);
      wait_idle("f8_drain");
      repeat (4) @(posedge clk);
      #2 chk("ovr_set", int'(overrun), 1);
      chk("ovr_no_frame", int'(busy), 0);

      // Overrun coinciding with clearErr stays set.
      push_task(2, 3); push_done(7);
      tick(6'b000100, 1'b1);
      @(posedge clk);
      #1 begin frameTick = 1'b1; clearErr = 1'b1; end
      @(posedge clk);
      #1 begin frameTick = 1'b0; clearErr = 1'b0; end
      chk("ovr_set_wins", int'(overrun), 1);
      wait_idle("f8b_drain");
      pulse_clear();
      #1 chk("ovr_cleared", int'(overrun), 0);

      // Reset during task 3's RUN drops enables at once.
      end_after[3] = 5;
      push_task(3, 1);
      tick(6'b001000, 1'b1);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (taskEnable[3]) seen = 1'b1;
         end
         chk("f9_en3_seen", int'(seen), 1);
      end
      @(posedge clk);
      #2 reset = 1'b1;
      #1 chk("f9_en_drop", int'(taskEnable), 0);
      chk("f9_busy_drop", int'(busy), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      set_ends(2);
      wait_idle("f9_drain");

      // First frame after the mid-frame reset draws all tasks again.
      for (int i = 0; i < 6; i++) push_task(i, 2);
      push_done(26);
      tick(6'b000000, 1'b1);
      wait_idle("f10_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got time %0t, required completion", $time);
      $fatal(1);
   end

endmodule
